// File: rtl/audio_echo_delay.sv
// Single-channel audio delay/echo line on a circular simple-dual-port RAM.
// Two-stage pipeline: RAM read + operand capture, then tap select / mix / saturate.
module audio_echo_delay #(
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 12,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] delay_num,
  input  logic [GAIN_W-1:0] gain,
  input  logic              mode,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] delayed_data,
  output logic              primed,
  output logic              sat_pulse
);

  localparam int SUM_W = DATA_W + GAIN_W + 1;
  localparam logic [ADDR_W-1:0] FILL_MAX = '1;
  localparam logic signed [SUM_W-1:0] MAX_V = {{(GAIN_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MIN_V = {{(GAIN_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] fill;
  logic [ADDR_W-1:0] rd_addr;
  logic              take;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_in;
  logic              s1_mode;
  logic [GAIN_W-1:0] s1_gain;
  logic              s1_bypass;
  logic              s1_zero;
  logic              s1_primed;

  logic [DATA_W-1:0]        tap;
  logic [SUM_W-1:0]         tap_ext;
  logic [SUM_W-1:0]         in_ext;
  logic [SUM_W-1:0]         gain_ext;
  logic signed [SUM_W-1:0]  prod;
  logic signed [SUM_W-1:0]  sum;
  logic [DATA_W-1:0]        mix;
  logic                     mix_sat;
  logic                     emit;

  assign take    = in_valid & ~flush;
  assign rd_addr = wr_ptr - delay_num;
  assign emit    = s1_valid & ~flush;

  // Buffer storage is never reset; the fill counter guarantees stale words are never emitted.
  always_ff @(posedge clk) begin
    if (take) begin
      mem[wr_ptr] <= in_data;
      rd_data     <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      fill      <= '0;
      s1_valid  <= 1'b0;
      s1_in     <= '0;
      s1_mode   <= 1'b0;
      s1_gain   <= '0;
      s1_bypass <= 1'b0;
      s1_zero   <= 1'b0;
      s1_primed <= 1'b0;
    end else begin
      s1_valid <= take;
      if (flush) begin
        wr_ptr <= '0;
        fill   <= '0;
      end else if (in_valid) begin
        wr_ptr    <= wr_ptr + ADDR_W'(1);
        if (fill != FILL_MAX) fill <= fill + ADDR_W'(1);
        s1_in     <= in_data;
        s1_mode   <= mode;
        s1_gain   <= gain;
        s1_bypass <= (delay_num == '0);
        s1_zero   <= (fill < delay_num);
        s1_primed <= (fill >= delay_num);
      end
    end
  end

  // Zero delay bypasses the RAM, so a read of the word being written is never used.
  always_comb begin
    tap = rd_data;
    if (s1_bypass)    tap = s1_in;
    else if (s1_zero) tap = '0;
  end

  always_comb begin
    tap_ext  = {{(GAIN_W+1){tap[DATA_W-1]}}, tap};
    in_ext   = {{(GAIN_W+1){s1_in[DATA_W-1]}}, s1_in};
    gain_ext = {{(DATA_W+1){1'b0}}, s1_gain};
    prod     = $signed(tap_ext) * $signed(gain_ext);
    sum      = $signed(in_ext) + (prod >>> GAIN_FRAC);
    mix      = sum[DATA_W-1:0];
    mix_sat  = 1'b0;
    if (sum > MAX_V) begin
      mix     = MAX_V[DATA_W-1:0];
      mix_sat = 1'b1;
    end else if (sum < MIN_V) begin
      mix     = MIN_V[DATA_W-1:0];
      mix_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      delayed_data <= '0;
      primed       <= 1'b0;
      sat_pulse    <= 1'b0;
    end else begin
      out_valid <= emit;
      sat_pulse <= 1'b0;
      if (emit) begin
        delayed_data <= tap;
        out_data     <= s1_mode ? mix : tap;
        sat_pulse    <= s1_mode & mix_sat;
        primed       <= s1_primed;
      end
    end
  end

endmodule
